// File: rtl/packet_sender.sv
// Per-ingress-port packet generator for the switch write interface.
// Emits sop, header, numbered payload words and eop, singly or as a burst.
module packet_sender #(
  parameter int unsigned TX_PORT         = 0,
  parameter int unsigned PORT_NUM        = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned PRIORITY        = 8,
  parameter int unsigned DATA_LENGTH_MAX = 1024,
  localparam int unsigned WIDTH_SEL      = $clog2(PORT_NUM),
  localparam int unsigned WIDTH_PRI      = $clog2(PRIORITY),
  localparam int unsigned WIDTH_LEN      = $clog2(DATA_LENGTH_MAX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  ready,
  input  logic                  single,
  input  logic [19:0]           send_cycle,
  output logic                  done,
  input  logic [WIDTH_SEL-1:0]  dest,
  input  logic [WIDTH_PRI-1:0]  prio,
  input  logic [WIDTH_LEN-1:0]  length,
  output logic                  wr_sop,
  output logic                  wr_eop,
  output logic                  wr_vld,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned HDR_PRI_LSB = WIDTH_SEL;
  localparam int unsigned HDR_LEN_LSB = WIDTH_SEL + WIDTH_PRI;
  localparam int unsigned HDR_SRC_LSB = WIDTH_SEL + WIDTH_PRI + WIDTH_LEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOP,
    S_HDR,
    S_DATA,
    S_EOP,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH_SEL-1:0]  dest_q, dest_d;
  logic [WIDTH_PRI-1:0]  prio_q, prio_d;
  logic [WIDTH_LEN-1:0]  len_q, len_d;
  logic                  single_q, single_d;
  logic [19:0]           burst_q, burst_d;
  logic [19:0]           pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH_LEN-1:0]  idx_q, idx_d;
  logic [WIDTH_LEN-1:0]  last_idx;

  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] hdr_word;
  logic [DATA_WIDTH-1:0] pay_word;

  // A zero length still carries one payload word; the header keeps the raw value.
  assign last_idx = (len_q == '0) ? '0 : len_q - WIDTH_LEN'(1);

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    prio_d    = prio_q;
    len_d     = len_q;
    single_d  = single_q;
    burst_d   = burst_q;
    pkt_cnt_d = pkt_cnt_q;
    idx_d     = idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dest_d    = dest;
          prio_d    = prio;
          len_d     = length;
          single_d  = single;
          burst_d   = (send_cycle == '0) ? 20'd1 : send_cycle;
          pkt_cnt_d = '0;
          idx_d     = '0;
          state_d   = S_SOP;
        end
      end
      S_SOP: begin
        idx_d   = '0;
        state_d = S_HDR;
      end
      S_HDR: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        if (idx_q == last_idx) begin
          state_d = S_EOP;
        end else begin
          idx_d = idx_q + WIDTH_LEN'(1);
        end
      end
      S_EOP: begin
        pkt_cnt_d = pkt_cnt_q + 20'd1;
        if (single_q || (pkt_cnt_d == burst_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_SOP;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    hdr_word = '0;
    hdr_word[WIDTH_SEL-1:0]               = dest_q;
    hdr_word[HDR_PRI_LSB +: WIDTH_PRI]    = prio_q;
    hdr_word[HDR_LEN_LSB +: WIDTH_LEN]    = len_q;
    hdr_word[HDR_SRC_LSB +: 16]           = 16'(TX_PORT);

    pay_word = '0;
    pay_word[DATA_WIDTH-1 -: 8]           = 8'(TX_PORT);
    pay_word[WIDTH_LEN-1:0]               = idx_d;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
    sop_d   = (state_d == S_SOP);
    eop_d   = (state_d == S_EOP);
    vld_d   = (state_d == S_HDR) || (state_d == S_DATA);
    data_d  = '0;
    if (state_d == S_HDR) begin
      data_d = hdr_word;
    end else if (state_d == S_DATA) begin
      data_d = pay_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dest_q    <= '0;
      prio_q    <= '0;
      len_q     <= '0;
      single_q  <= 1'b0;
      burst_q   <= '0;
      pkt_cnt_q <= '0;
      idx_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      vld_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      prio_q    <= prio_d;
      len_q     <= len_d;
      single_q  <= single_d;
      burst_q   <= burst_d;
      pkt_cnt_q <= pkt_cnt_d;
      idx_q     <= idx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign wr_sop  = sop_q;
  assign wr_eop  = eop_q;
  assign wr_vld  = vld_q;
  assign wr_data = data_q;

  a_strobes_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0({wr_sop, wr_eop, wr_vld}));

  a_data_zero_when_invalid: assert property (
    @(posedge clk) disable iff (!rst_n) !wr_vld |-> (wr_data == '0));

endmodule

// File: tb/tb_packet_sender.sv
// Bench for packet_sender: commands are replayed against a cycle-trace model
// built from the packet format rules, and the observed trace is compared.
module tb_packet_sender;

  localparam int TXP = 1;
  localparam int WS  = $clog2(4);
  localparam int WP  = $clog2(8);
  localparam int WL  = $clog2(1024);

  typedef logic [36:0] obs_t;  // {ready, sop, eop, vld, done, data[31:0]}

  localparam obs_t IDLE_OBS = {1'b1, 4'b0000, 32'h0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic        single;
  logic [19:0] send_cycle;
  logic        done;
  logic [1:0]  dest;
  logic [2:0]  prio;
  logic [9:0]  length;
  logic        wr_sop;
  logic        wr_eop;
  logic        wr_vld;
  logic [31:0] wr_data;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  packet_sender #(
    .TX_PORT(TXP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .single    (single),
    .send_cycle(send_cycle),
    .done      (done),
    .dest      (dest),
    .prio      (prio),
    .length    (length),
    .wr_sop    (wr_sop),
    .wr_eop    (wr_eop),
    .wr_vld    (wr_vld),
    .wr_data   (wr_data)
  );

  function automatic obs_t sample();
    return {ready, wr_sop, wr_eop, wr_vld, done, wr_data};
  endfunction

  // Expected per-cycle trace, starting the cycle after the accepting edge
  // and ending with one idle cycle after done.
  function automatic void build_expected(input bit sgl, input int unsigned sc,
                                         input int unsigned d, input int unsigned p,
                                         input int unsigned l);
    int unsigned nwords;
    int unsigned npk;
    logic [31:0] w;
    exp_q.delete();
    nwords = (l == 0) ? 1 : l;
    npk    = sgl ? 1 : ((sc == 0) ? 1 : sc);
    for (int unsigned pk = 0; pk < npk; pk++) begin
      exp_q.push_back({1'b0, 4'b1000, 32'h0});
      w = 32'(d + (p << WS) + (l << (WS + WP)) + (TXP << (WS + WP + WL)));
      exp_q.push_back({1'b0, 4'b0010, w});
      for (int unsigned k = 0; k < nwords; k++) begin
        w = 32'((TXP << 24) + k);
        exp_q.push_back({1'b0, 4'b0010, w});
      end
      exp_q.push_back({1'b0, 4'b0100, 32'h0});
      if (pk + 1 < npk) exp_q.push_back({1'b0, 4'b0000, 32'h0});
    end
    exp_q.push_back({1'b0, 4'b0001, 32'h0});
    exp_q.push_back(IDLE_OBS);
  endfunction

  // Called at a sample point (posedge + 1); the next edge accepts the command.
  task automatic play(input bit sgl, input logic [19:0] sc, input logic [1:0] d,
                      input logic [2:0] p, input logic [9:0] l, input int ncyc,
                      input int repulse_at, input bit hold);
    obs_q.delete();
    single     = sgl;
    send_cycle = sc;
    dest       = d;
    prio       = p;
    length     = l;
    start      = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      obs_q.push_back(sample());
      if (i == 0 && !hold) start = 1'b0;
      if (i == repulse_at) begin
        start      = 1'b1;
        dest       = ~d;
        prio       = ~p;
        length     = l + 10'd5;
        single     = ~sgl;
        send_cycle = 20'd3;
      end
      if (i == repulse_at + 1) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; single = 1'b0; send_cycle = '0; dest = '0; prio = '0; length = '0;
    #12;
    checks++;
    if (sample() !== IDLE_OBS) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", sample(), IDLE_OBS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sample() !== IDLE_OBS) begin
        fails++;
        $display("FAIL idle_after_reset cycle %0d: got %h expected %h", i, sample(), IDLE_OBS);
      end
    end
  endtask

  task automatic test_single_basic();
    int first_sop;
    int first_done;
    build_expected(1, 0, 2, 1, 16);
    play(1'b1, 20'd0, 2'd2, 3'd1, 10'd16, exp_q.size(), -1, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL single_basic cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    first_sop = -1;
    first_done = -1;
    foreach (obs_q[i]) begin
      if (obs_q[i][35] && first_sop < 0) first_sop = i;
      if (obs_q[i][32] && first_done < 0) first_done = i;
    end
    checks++;
    if (first_done - first_sop + 1 !== 20) begin
      fails++;
      $display("FAIL sop_to_done_span: got %0d expected 20", first_done - first_sop + 1);
    end
  endtask

  task automatic test_burst();
    int sops;
    int dones;
    logic [1:0] d;
    logic [2:0] p;
    d = 2'($urandom_range(0, 3));
    p = 3'($urandom_range(0, 7));
    build_expected(0, 3, d, p, 4);
    play(1'b0, 20'd3, d, p, 10'd4, exp_q.size(), -1, 1'b0);
    sops = 0;
    dones = 0;
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL burst cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
      sops  += int'(obs_q[i][35]);
      dones += int'(obs_q[i][32]);
    end
    checks++;
    if (sops !== 3 || dones !== 1) begin
      fails++;
      $display("FAIL burst_counts: got sop=%0d done=%0d expected sop=3 done=1", sops, dones);
    end
  endtask

  task automatic test_zero_length();
    build_expected(1, 0, 1, 5, 0);
    play(1'b1, 20'd0, 2'd1, 3'd5, 10'd0, exp_q.size(), -1, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL zero_length cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    // send_cycle = 0 in burst mode behaves like a single packet
    build_expected(0, 0, 3, 2, 2);
    play(1'b0, 20'd0, 2'd3, 3'd2, 10'd2, exp_q.size(), -1, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL zero_send_cycle cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ignore_restart();
    build_expected(1, 0, 1, 3, 8);
    play(1'b1, 20'd0, 2'd1, 3'd3, 10'd8, exp_q.size(), 3, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL ignore_restart cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sample() !== IDLE_OBS) begin
        fails++;
        $display("FAIL no_second_packet cycle %0d: got %h expected %h", i, sample(), IDLE_OBS);
      end
    end
  endtask

  task automatic test_start_held();
    build_expected(1, 0, 0, 7, 3);
    play(1'b1, 20'd0, 2'd0, 3'd7, 10'd3, exp_q.size(), -1, 1'b1);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL start_held_first cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    build_expected(0, 2, 2, 4, 2);
    play(1'b0, 20'd2, 2'd2, 3'd4, 10'd2, exp_q.size(), -1, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL start_held_second cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_data();
    build_expected(1, 0, 3, 6, 12);
    play(1'b1, 20'd0, 2'd3, 3'd6, 10'd12, 5, -1, 1'b0);
    checks++;
    if (obs_q[4] !== exp_q[4]) begin
      fails++;
      $display("FAIL pre_reset_data: got %h expected %h", obs_q[4], exp_q[4]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample() !== IDLE_OBS) begin
      fails++;
      $display("FAIL async_reset_clear: got %h expected %h", sample(), IDLE_OBS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build_expected(1, 0, 1, 2, 5);
    play(1'b1, 20'd0, 2'd1, 3'd2, 10'd5, exp_q.size(), -1, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL post_reset_packet cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit          sgl;
    logic [19:0] sc;
    logic [1:0]  d;
    logic [2:0]  p;
    logic [9:0]  l;
    for (int n = 0; n < 10; n++) begin
      sgl = 1'($urandom_range(0, 1));
      sc  = 20'($urandom_range(0, 4));
      d   = 2'($urandom_range(0, 3));
      p   = 3'($urandom_range(0, 7));
      l   = 10'($urandom_range(0, 20));
      build_expected(sgl, sc, d, p, l);
      play(sgl, sc, d, p, l, exp_q.size(), -1, 1'b0);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL random cmd %0d cycle %0d: got %h expected %h", n, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_single_basic();
    test_burst();
    test_zero_length();
    test_ignore_restart();
    test_start_held();
    test_reset_mid_data();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
